// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan driver:
//   SEG_OFF    - all segments dark (active-low pattern gfedcba)
//   SEG_TABLE  - hex glyphs 0..F, active-low, bit 6 = g ... bit 0 = a
//   scan_state_t - slot phase: blanking gap or digit display
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational hex-to-7-segment decoder.
// Ports:
//   i_nibble [3:0] - hex value to display
//   o_seg_n  [6:0] - segments g..a, active-low
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Each digit owns a slot of SCAN_DIV cycles; the first GAP_CYC cycles of a
// slot are blanked to suppress ghosting. New values are staged in a pending
// register and only promoted to the displayed (shadow) copy at a frame
// boundary, so a frame never shows a mix of old and new digits.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   data[15:0] - four hex nibbles, [3:0] = digit 0 (rightmost)
//   dp[3:0]    - decimal-point request per digit, active-high
//   lzb        - leading-zero blanking enable
//   load       - one-cycle strobe capturing data/dp/lzb
//   seg_n[6:0] - segments g..a, active-low (registered)
//   dp_n       - decimal point, active-low (registered)
//   an_n[3:0]  - digit anodes, active-low (registered)
//   frame_done - one-cycle pulse following each frame boundary (registered)
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 8000,
    parameter int GAP_CYC  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic [3:0]  dp,
    input  logic        lzb,
    input  logic        load,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    scan_state_t      r_state;
    scan_state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_digit;

    logic [15:0]      r_pend_data;
    logic [3:0]       r_pend_dp;
    logic             r_pend_lzb;
    logic             r_pend_flag;
    logic [15:0]      r_shad_data;
    logic [3:0]       r_shad_dp;
    logic             r_shad_lzb;

    logic [6:0]       r_seg_n;
    logic             r_dp_n;
    logic [3:0]       r_an_n;
    logic             r_frame_done;

    logic             w_slot_end;
    logic             w_gap_end;
    logic             w_frame_end;
    logic [3:0]       w_nibble;
    logic [6:0]       w_glyph;
    logic [3:0]       w_lead_zero;
    logic             w_blank;
    logic [6:0]       w_seg_n_nx;
    logic             w_dp_n_nx;
    logic [3:0]       w_an_n_nx;

    assign w_slot_end  = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_gap_end   = (r_cnt == CNT_W'(GAP_CYC - 1));
    assign w_frame_end = w_slot_end && (r_digit == 2'd3);

    // Nibble of the digit currently being scanned, taken from the shadow copy.
    always_comb begin
        w_nibble = r_shad_data[3:0];
        case (r_digit)
            2'd0: w_nibble = r_shad_data[3:0];
            2'd1: w_nibble = r_shad_data[7:4];
            2'd2: w_nibble = r_shad_data[11:8];
            2'd3: w_nibble = r_shad_data[15:12];
            default: w_nibble = r_shad_data[3:0];
        endcase
    end

    seg7_hex_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg_n  (w_glyph)
    );

    // w_lead_zero[k] is set when digits 3..k are all zero. Bit 0 is tied low
    // so the rightmost digit always shows, even for a value of zero.
    assign w_lead_zero[3] = (r_shad_data[15:12] == 4'h0);
    assign w_lead_zero[2] = w_lead_zero[3] && (r_shad_data[11:8] == 4'h0);
    assign w_lead_zero[1] = w_lead_zero[2] && (r_shad_data[7:4] == 4'h0);
    assign w_lead_zero[0] = 1'b0;
    assign w_blank        = r_shad_lzb && w_lead_zero[r_digit];

    // NOTE: every always_comb output gets a default on entry, so no path
    // through the block can leave a value held and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_an_n_nx    = 4'b1111;
        w_seg_n_nx   = SEG_OFF;
        w_dp_n_nx    = 1'b1;
        case (r_state)
            ST_GAP: begin
                if (w_gap_end) begin
                    w_next_state = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_slot_end) begin
                    w_next_state = ST_GAP;
                end
                if (!w_blank) begin
                    w_an_n_nx  = ~(4'b0001 << r_digit);
                    w_seg_n_nx = w_glyph;
                    w_dp_n_nx  = ~r_shad_dp[r_digit];
                end
            end
            default: w_next_state = ST_GAP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_GAP;
            r_cnt        <= '0;
            r_digit      <= 2'd0;
            r_an_n       <= 4'b1111;
            r_seg_n      <= SEG_OFF;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end) begin
                r_digit <= r_digit + 2'd1;
            end
            r_an_n       <= w_an_n_nx;
            r_seg_n      <= w_seg_n_nx;
            r_dp_n       <= w_dp_n_nx;
            r_frame_done <= w_frame_end;
        end
    end

    // Double buffering: loads land in pending; the shadow copy moves only at
    // a frame boundary. A load on the boundary cycle bypasses pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_data <= 16'h0000;
            r_pend_dp   <= 4'h0;
            r_pend_lzb  <= 1'b0;
            r_pend_flag <= 1'b0;
            r_shad_data <= 16'h0000;
            r_shad_dp   <= 4'h0;
            r_shad_lzb  <= 1'b0;
        end else if (w_frame_end) begin
            if (load) begin
                r_shad_data <= data;
                r_shad_dp   <= dp;
                r_shad_lzb  <= lzb;
            end else if (r_pend_flag) begin
                r_shad_data <= r_pend_data;
                r_shad_dp   <= r_pend_dp;
                r_shad_lzb  <= r_pend_lzb;
            end
            r_pend_flag <= 1'b0;
        end else if (load) begin
            r_pend_data <= data;
            r_pend_dp   <= dp;
            r_pend_lzb  <= lzb;
            r_pend_flag <= 1'b1;
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with SCAN_DIV=8, GAP_CYC=2.
// The reference model works from absolute cycle numbers since reset: slot
// position and digit come from division, the displayed value for a frame is
// the last load made before that frame began, and leading-zero blanking is a
// shift test on the whole word.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int SD    = 8;
    localparam int GAP   = 2;
    localparam int FRAME = 4 * SD;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lzb;
    logic        load;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    seg7_scan_driver #(
        .SCAN_DIV (SD),
        .GAP_CYC  (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp         (dp),
        .lzb        (lzb),
        .load       (load),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] dec_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [12:0] ALL_OFF = {4'b1111, 7'b1111111, 1'b1, 1'b0};

    int errors = 0;
    int checks = 0;

    // Model state: cycle number since reset release, displayed values for the
    // current frame, and the most recent load seen so far.
    int          n;
    logic [15:0] m_data, l_data;
    logic [3:0]  m_dp,   l_dp;
    logic        m_lzb,  l_lzb;

    logic [12:0] e, a;

    task automatic model_reset();
        n = 0;
        m_data = 16'h0; m_dp = 4'h0; m_lzb = 1'b0;
        l_data = 16'h0; l_dp = 4'h0; l_lzb = 1'b0;
    endtask

    // Expected {an_n, seg_n, dp_n, frame_done} one cycle after cycle c_n.
    function automatic logic [12:0] model_out(int c_n, logic [15:0] d,
                                              logic [3:0] p, logic z);
        int          c;
        int          g;
        logic [3:0]  nib;
        logic [15:0] upper;
        logic        fd;
        c     = c_n % SD;
        g     = (c_n / SD) % 4;
        upper = d >> (4 * g);
        nib   = upper[3:0];
        fd    = (c == SD - 1) && (g == 3);
        if (c < GAP || (z && g != 0 && upper == 16'h0))
            return {4'b1111, 7'b1111111, 1'b1, fd};
        return {~(4'b0001 << g), dec_tab[nib], ~p[g], fd};
    endfunction

    // Advance one cycle with the given stimulus; returns model expectation
    // and the sampled outputs for that cycle.
    task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] p,
                        input bit z, output logic [12:0] exp_o,
                        output logic [12:0] act_o);
        if (n % FRAME == 0) begin
            m_data = l_data; m_dp = l_dp; m_lzb = l_lzb;
        end
        exp_o = model_out(n, m_data, m_dp, m_lzb);
        if (ld) begin
            l_data = d; l_dp = p; l_lzb = z;
        end
        load = ld; data = d; dp = p; lzb = z;
        @(posedge clk);
        #1;
        act_o = {an_n, seg_n, dp_n, frame_done};
        load = 1'b0;
        n++;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; data = 16'hFFFF; dp = 4'hF; lzb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            a = {an_n, seg_n, dp_n, frame_done};
            checks++;
            if (a !== ALL_OFF) begin
                errors++;
                $display("FAIL reset_state edge=%0d got=%b exp=%b", i, a, ALL_OFF);
            end
        end
        rst = 1'b0; load = 1'b0;
        model_reset();
    endtask

    task automatic test_scan();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b0, e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scan n=%0d got=%b exp=%b", n - 1, a, e);
            end
        end
    endtask

    task automatic test_load_midframe();
        while (n % FRAME != 10) begin
            step(1'b0, 16'h0, 4'h0, 1'b0, e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL midload_pre n=%0d got=%b exp=%b", n - 1, a, e);
            end
        end
        step(1'b1, 16'h12AF, 4'h0, 1'b0, e, a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL midload_strobe n=%0d got=%b exp=%b", n - 1, a, e);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b0, e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL midload n=%0d got=%b exp=%b", n - 1, a, e);
            end
        end
    endtask

    // A mid-frame load is superseded by a second load on the boundary cycle,
    // which must show from digit 0 of the very next frame.
    task automatic test_load_boundary();
        logic [15:0] d;
        for (int rep = 0; rep < 2; rep++) begin
            while (n % FRAME != FRAME - 1) begin
                d = 16'($urandom);
                step((n % FRAME) == 20, d, 4'($urandom), 1'b0, e, a);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL boundary_pre n=%0d got=%b exp=%b", n - 1, a, e);
                end
            end
            d = 16'($urandom);
            step(1'b1, d, 4'($urandom), 1'b0, e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL boundary_strobe n=%0d got=%b exp=%b", n - 1, a, e);
            end
            for (int i = 0; i < FRAME; i++) begin
                step(1'b0, 16'h0, 4'h0, 1'b0, e, a);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL boundary n=%0d got=%b exp=%b", n - 1, a, e);
                end
            end
        end
    endtask

    task automatic test_lzb();
        step(1'b1, 16'h0050, 4'h0, 1'b1, e, a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL lzb_strobe n=%0d got=%b exp=%b", n - 1, a, e);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b0, e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL lzb n=%0d got=%b exp=%b", n - 1, a, e);
            end
        end
    endtask

    task automatic test_dp();
        step(1'b1, 16'($urandom), 4'b0100, 1'b0, e, a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL dp_strobe n=%0d got=%b exp=%b", n - 1, a, e);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b0, e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL dp n=%0d got=%b exp=%b", n - 1, a, e);
            end
        end
    endtask

    // Every glyph 0..F shown at least once, one frame per group of four.
    task automatic test_all_glyphs();
        logic [15:0] groups [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < FRAME; i++) begin
                step(i == 0, groups[k], 4'($urandom), 1'b0, e, a);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL glyphs n=%0d got=%b exp=%b", n - 1, a, e);
                end
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b0, e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL glyphs_tail n=%0d got=%b exp=%b", n - 1, a, e);
            end
        end
    endtask

    // Random loads with nibbles biased toward zero to exercise blanking.
    task automatic test_random();
        logic [15:0] d;
        for (int i = 0; i < 12 * FRAME; i++) begin
            for (int k = 0; k < 4; k++)
                d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            step($urandom_range(0, 15) == 0, d, 4'($urandom),
                 1'($urandom), e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL random n=%0d got=%b exp=%b", n - 1, a, e);
            end
        end
    endtask

    task automatic test_reset_midshow();
        while (!((n % SD) == 4 && ((n / SD) % 4) == 2)) begin
            step(1'b0, 16'h0, 4'h0, 1'b0, e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL rstshow_pre n=%0d got=%b exp=%b", n - 1, a, e);
            end
        end
        rst = 1'b1; load = 1'b1; data = 16'h9876; dp = 4'hF; lzb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            a = {an_n, seg_n, dp_n, frame_done};
            checks++;
            if (a !== ALL_OFF) begin
                errors++;
                $display("FAIL rstshow_off edge=%0d got=%b exp=%b", i, a, ALL_OFF);
            end
        end
        rst = 1'b0; load = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b0, e, a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL rstshow_restart n=%0d got=%b exp=%b", n - 1, a, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data = 16'h0; dp = 4'h0; lzb = 1'b0;
        model_reset();
        test_reset();
        test_scan();
        test_load_midframe();
        test_load_boundary();
        test_lzb();
        test_dp();
        test_all_glyphs();
        test_random();
        test_reset_midshow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 8000: clock cycles per digit slot; legal range SCAN_DIV >= 4.
REQ-002 Parameter GAP_CYC, default 16: blanking cycles at the start of each slot; legal range 1 <= GAP_CYC < SCAN_DIV.
REQ-003 Port clk  in  1  single system clock; all logic rising-edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Port data  in  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 Port dp  in  4  decimal-point request per digit, active-high.
REQ-007 Port lzb  in  1  leading-zero blanking enable.
REQ-008 Port load  in  1  one-cycle strobe that captures data, dp and lzb.
REQ-009 Port seg_n  out  7  segments g..a on bits [6:0], active-low.
REQ-010 Port dp_n  out  1  decimal point, active-low.
REQ-011 Port an_n  out  4  digit anodes, active-low, one-hot-low when displaying.
REQ-012 Port frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Slot counter SHALL count 0..SCAN_DIV-1 and wrap; a slot ends when the counter equals SCAN_DIV-1.
REQ-014 FSM SHALL have two states, GAP (counter < GAP_CYC) and SHOW (counter >= GAP_CYC); GAP->SHOW at counter = GAP_CYC-1; SHOW->GAP at slot end.
REQ-015 In GAP: an_n=1111, seg_n=1111111, dp_n=1.
REQ-016 In SHOW: an_n bit [digit]=0; seg_n = decode(shadow nibble[digit]); dp_n = ~shadow_dp[digit].
REQ-017 Digit index SHALL advance 0->1->2->3->0 at each slot end.
REQ-018 Frame boundary = slot end with digit 3; frame_done=1 for exactly that cycle; period = 4*SCAN_DIV cycles.
REQ-019 All outputs registered; pins reflect state/counter with exactly one cycle latency.
REQ-020 On load=1, data/dp/lzb go to a pending register and pending flag is set; repeated loads before the boundary: last wins.
REQ-021 At frame boundary, pending is copied to shadow and the flag cleared; shadow never changes mid-frame.
REQ-022 If load coincides with the frame boundary, the strobed values go directly to shadow and the flag ends cleared.
REQ-023 Decode table (gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-024 With shadow lzb=1: each zero digit from digit 3 downward, up to the first non-zero digit, SHALL be blanked (anode kept off, dp_n=1); digit 0 is never blanked.

Reset
REQ-025 On rst=1: counter=0, digit=0, state=GAP, shadow and pending=0, flag clear, an_n=1111, seg_n=1111111, dp_n=1, frame_done=0.
REQ-026 rst SHALL override load and every in-progress slot; the first post-reset frame displays "0000".

Structure
REQ-027 Package seg7_pkg SHALL hold the 16-entry decode constant table, the SEG_OFF constant (1111111) and the FSM state type.
REQ-028 Decode SHALL be a combinational sub-module seg7_hex_decode (4-bit in, 7-bit active-low out).

Verification (SCAN_DIV=8, GAP_CYC=2)
REQ-029 Reset, then run 64 cycles -> per slot 2 cycles all-off, then 6 cycles with an_n 1110/1101/1011/0111 in turn; seg_n=1000000; frame_done every 32 cycles.
REQ-030 load data=16'h12AF at cycle 10 of a frame -> old value held to the boundary; next frame digit0 seg_n=0001110, digit1 0001000, digit2 0100100, digit3 1111001.
REQ-031 load coincident with frame_done -> new data displayed from digit 0 of the immediately following frame.
REQ-032 lzb=1, data=16'h0050 -> digits 3 and 2 keep anodes off throughout; digit 1 shows 0010010; digit 0 shows 1000000.
REQ-033 dp=4'b0100 -> dp_n=0 only during SHOW of digit 2.
REQ-034 Assert rst during SHOW of digit 2 -> next cycle all outputs off; after release the scan restarts at digit 0 with a 2-cycle GAP.
